// File: rtl/rpn_stack_core.sv
// RPN stack engine: TOS held in a register, lower entries in a synchronous-read RAM.
// Commands arrive over valid/ready; two-operand ops take IDLE->READ->EXEC.
module rpn_stack_core #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             cmd_ready,
    output logic [WIDTH-1:0] top,
    output logic [AW:0]      depth,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam logic [2:0] OP_PUSH  = 3'b000;
    localparam logic [2:0] OP_POP   = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_DUP   = 3'b101;
    localparam logic [2:0] OP_SWAP  = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    localparam logic [1:0] E_UNDER = 2'b01;
    localparam logic [1:0] E_OVER  = 2'b10;
    localparam logic [1:0] E_ARITH = 2'b11;

    localparam logic [AW:0] D_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] D_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0] D_ONE  = (AW+1)'(1);
    localparam logic [AW:0] D_TWO  = (AW+1)'(2);

    typedef enum logic [1:0] {S_IDLE = 2'b00, S_READ = 2'b01, S_EXEC = 2'b10} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   top_q, top_d;
    logic [AW:0]        depth_q, depth_d;
    logic               err_q, err_d;
    logic [1:0]         code_q, code_d;
    logic               ready_q;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   rd_q;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic               wr_en_s;
    logic [AW-1:0]      wr_addr_s;
    logic [AW-1:0]      sp_addr_s;
    logic [AW-1:0]      nos_addr_s;
    logic               raise_s;
    logic [1:0]         raise_code_s;
    logic               clr_s;
    logic [WIDTH:0]     alu_s;

    // Returns {overflow, result} for the arithmetic opcodes; NOS is the left operand.
    function automatic logic [WIDTH:0] alu(input logic [2:0] op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
        logic [WIDTH:0]     sum;
        logic [2*WIDTH-1:0] prod;
        sum  = {1'b0, a} + {1'b0, b};
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        case (op)
            OP_ADD:  alu = sum;
            OP_SUB:  alu = {(a < b), a - b};
            OP_MUL:  alu = {(|prod[2*WIDTH-1:WIDTH]), prod[WIDTH-1:0]};
            default: alu = {1'b0, a};
        endcase
    endfunction

    assign sp_addr_s  = AW'(depth_q - D_ONE);
    assign nos_addr_s = AW'(depth_q - D_TWO);
    assign alu_s      = alu(op_q, rd_q, top_q);

    // Next-state, datapath and error-flag decisions.
    always_comb begin
        state_d      = state_q;
        top_d        = top_q;
        depth_d      = depth_q;
        err_d        = err_q;
        code_d       = code_q;
        op_d         = op_q;
        wr_en_s      = 1'b0;
        wr_addr_s    = sp_addr_s;
        raise_s      = 1'b0;
        raise_code_s = 2'b00;
        clr_s        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && ready_q) begin
                    op_d = cmd_op;
                    case (cmd_op)
                        OP_PUSH: begin
                            if (depth_q == D_FULL) begin
                                raise_s = 1'b1; raise_code_s = E_OVER;
                            end else begin
                                wr_en_s = (depth_q != D_ZERO);
                                top_d   = cmd_data;
                                depth_d = depth_q + D_ONE;
                            end
                        end
                        OP_POP: begin
                            if (depth_q == D_ZERO) begin
                                raise_s = 1'b1; raise_code_s = E_UNDER;
                            end else if (depth_q == D_ONE) begin
                                depth_d = D_ZERO;
                                top_d   = {WIDTH{1'b0}};
                            end else begin
                                state_d = S_READ;
                            end
                        end
                        OP_ADD, OP_SUB, OP_MUL, OP_SWAP: begin
                            if (depth_q < D_TWO) begin
                                raise_s = 1'b1; raise_code_s = E_UNDER;
                            end else begin
                                state_d = S_READ;
                            end
                        end
                        OP_DUP: begin
                            if (depth_q == D_ZERO) begin
                                raise_s = 1'b1; raise_code_s = E_UNDER;
                            end else if (depth_q == D_FULL) begin
                                raise_s = 1'b1; raise_code_s = E_OVER;
                            end else begin
                                wr_en_s = 1'b1;
                                depth_d = depth_q + D_ONE;
                            end
                        end
                        OP_CLEAR: begin
                            depth_d = D_ZERO;
                            top_d   = {WIDTH{1'b0}};
                            clr_s   = 1'b1;
                        end
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_IDLE;
                if (op_q == OP_SWAP) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = nos_addr_s;
                    top_d     = rd_q;
                end else begin
                    top_d   = alu_s[WIDTH-1:0];
                    depth_d = depth_q - D_ONE;
                    raise_s = alu_s[WIDTH];
                    raise_code_s = E_ARITH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Only the first error since the last clear is remembered.
        if (clr_s) begin
            err_d  = 1'b0;
            code_d = 2'b00;
        end else if (raise_s && !err_q) begin
            err_d  = 1'b1;
            code_d = raise_code_s;
        end else begin
            err_d  = err_q;
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            top_q   <= {WIDTH{1'b0}};
            depth_q <= D_ZERO;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            ready_q <= 1'b0;
            op_q    <= OP_PUSH;
        end else begin
            state_q <= state_d;
            top_q   <= top_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            code_q  <= code_d;
            ready_q <= (state_d == S_IDLE);
            op_q    <= op_d;
        end
    end

    // Stack RAM write port; a reset edge suppresses any pending write.
    always_ff @(posedge CLOCK_50) begin
        if (reset_n && wr_en_s) begin
            mem_q[wr_addr_s] <= top_q;
        end
    end

    // Synchronous NOS read issued in READ, consumed in EXEC.
    always_ff @(posedge CLOCK_50) begin
        if (state_q == S_READ) begin
            rd_q <= mem_q[nos_addr_s];
        end
    end

    assign cmd_ready = ready_q;
    assign top       = top_q;
    assign depth     = depth_q;
    assign err       = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_rpn_stack_core.sv
// Directed bench for rpn_stack_core at WIDTH=8, DEPTH=4 with hand-computed expectations.
module tb_rpn_stack_core;

    localparam logic [2:0] PUSH = 3'b000, POP = 3'b001, ADD = 3'b010, SUB = 3'b011,
                           MUL = 3'b100, DUP = 3'b101, SWAP = 3'b110, CLR = 3'b111;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n  = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op   = 3'b000;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready;
    logic [7:0] top;
    logic [2:0] depth;
    logic       err;
    logic [1:0] err_code;

    int compared = 0;
    int fails    = 0;
    int lat;

    rpn_stack_core #(.WIDTH(8), .DEPTH(4)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .cmd_valid(cmd_valid),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .cmd_ready(cmd_ready),
        .top      (top),
        .depth    (depth),
        .err      (err),
        .err_code (err_code)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input int t, input int d, input int e, input int c);
        check({tag, ".top"},   32'(top),      32'(t));
        check({tag, ".depth"}, 32'(depth),    32'(d));
        check({tag, ".err"},   32'(err),      32'(e));
        check({tag, ".code"},  32'(err_code), 32'(c));
    endtask

    // Issue one command from a negedge; return number of negedges until ready returns.
    task automatic do_cmd(input logic [2:0] op, input logic [7:0] data, output int n);
        int w;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge CLOCK_50);
            w++;
        end
        if (!cmd_ready) begin
            compared++;
            fails++;
            $error("FAIL ready_wait: observed cmd_ready=0 expected 1 within 20 cycles");
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge CLOCK_50);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = CLR;
        cmd_data  = 8'hAA;
        n = 0;
        do begin
            @(negedge CLOCK_50);
            n++;
        end while (!cmd_ready && n < 20);
    endtask

    initial begin
        // Reset
        reset_n = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        expect_state("reset", 0, 0, 0, 0);
        check("reset.ready", 32'(cmd_ready), 32'd0);
        reset_n = 1'b1;
        @(negedge CLOCK_50);
        check("post_reset.ready", 32'(cmd_ready), 32'd1);

        // 5 + 7
        do_cmd(PUSH, 8'd5, lat);
        check("push.lat", 32'(lat), 32'd1);
        do_cmd(PUSH, 8'd7, lat);
        do_cmd(ADD, 8'd0, lat);
        check("add.lat", 32'(lat), 32'd3);
        expect_state("add", 12, 1, 0, 0);

        // Single-entry POP, then 3 - 10 borrows
        do_cmd(POP, 8'd0, lat);
        check("pop1.lat", 32'(lat), 32'd1);
        expect_state("pop1", 0, 0, 0, 0);
        do_cmd(PUSH, 8'd3, lat);
        do_cmd(PUSH, 8'd10, lat);
        do_cmd(SUB, 8'd0, lat);
        expect_state("sub", 249, 1, 1, 3);
        do_cmd(PUSH, 8'd1, lat);
        expect_state("push_after_err", 1, 2, 1, 3);

        // Fill, overflow, drain
        do_cmd(CLR, 8'd0, lat);
        expect_state("clr1", 0, 0, 0, 0);
        do_cmd(PUSH, 8'd1, lat);
        do_cmd(PUSH, 8'd2, lat);
        do_cmd(PUSH, 8'd3, lat);
        do_cmd(PUSH, 8'd4, lat);
        expect_state("full", 4, 4, 0, 0);
        do_cmd(PUSH, 8'd9, lat);
        check("ovf.lat", 32'(lat), 32'd1);
        expect_state("ovf", 4, 4, 1, 2);
        do_cmd(DUP, 8'd0, lat);
        expect_state("dup_full", 4, 4, 1, 2);
        do_cmd(POP, 8'd0, lat);
        expect_state("pop_a", 3, 3, 1, 2);
        do_cmd(POP, 8'd0, lat);
        expect_state("pop_b", 2, 2, 1, 2);
        do_cmd(POP, 8'd0, lat);
        expect_state("pop_c", 1, 1, 1, 2);
        do_cmd(POP, 8'd0, lat);
        expect_state("pop_d", 0, 0, 1, 2);

        // Underflow from empty
        do_cmd(CLR, 8'd0, lat);
        do_cmd(POP, 8'd0, lat);
        expect_state("underflow", 0, 0, 1, 1);
        do_cmd(ADD, 8'd0, lat);
        expect_state("underflow_keep", 0, 0, 1, 1);
        do_cmd(CLR, 8'd0, lat);
        expect_state("clr2", 0, 0, 0, 0);

        // MUL overflow and clean MUL
        do_cmd(PUSH, 8'd16, lat);
        do_cmd(PUSH, 8'd17, lat);
        do_cmd(MUL, 8'd0, lat);
        expect_state("mul_ovf", 16, 1, 1, 3);
        do_cmd(CLR, 8'd0, lat);
        do_cmd(PUSH, 8'd2, lat);
        do_cmd(DUP, 8'd0, lat);
        expect_state("dup", 2, 2, 0, 0);
        do_cmd(MUL, 8'd0, lat);
        expect_state("mul", 4, 1, 0, 0);

        // SWAP then POP: [1,2] -> [2,1] -> [2]
        do_cmd(CLR, 8'd0, lat);
        do_cmd(PUSH, 8'd1, lat);
        do_cmd(PUSH, 8'd2, lat);
        do_cmd(SWAP, 8'd0, lat);
        check("swap.lat", 32'(lat), 32'd3);
        expect_state("swap", 1, 2, 0, 0);
        do_cmd(POP, 8'd0, lat);
        expect_state("swap_pop", 2, 1, 0, 0);

        // Reset during POP's READ state
        do_cmd(PUSH, 8'd5, lat);
        expect_state("pre_abort", 5, 2, 0, 0);
        cmd_valid = 1'b1;
        cmd_op    = POP;
        @(posedge CLOCK_50);
        #1;
        cmd_valid = 1'b0;
        @(negedge CLOCK_50);
        check("read.ready", 32'(cmd_ready), 32'd0);
        reset_n = 1'b0;
        @(negedge CLOCK_50);
        expect_state("abort", 0, 0, 0, 0);
        check("abort.ready", 32'(cmd_ready), 32'd0);
        reset_n = 1'b1;
        @(negedge CLOCK_50);
        check("release.ready", 32'(cmd_ready), 32'd1);
        do_cmd(PUSH, 8'd6, lat);
        expect_state("after_abort", 6, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
        $finish;
    end

endmodule
